cv_linescan: RTL and testbench

//  Line-buffer scanout stage downstream of the BG renderer. Once per scanline it reads the

---
 rtl/cv_linescan.sv | 171 +++++++++++++++++
 tb/tb_cv_linescan.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cv_linescan.sv
// cv_linescan: line-buffer scanout stage. Once per scanline it reads a finished
// line-buffer bank, splits each 64-bit word into four 16-bit pixels at the
// pixel-enable rate and substitutes bg_color for transparent pixels (bit15=1).
// Optional feature macro: CV_LINESCAN_CLEAR_EN (clear-after-read of each word).
module cv_linescan #(
   parameter int          WORDS   = 200,
   parameter logic [15:0] CLR_PIX = 16'h8000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        line_start,
   input  logic [1:0]  rd_bank,
   input  logic        pix_en,
   input  logic [14:0] bg_color,
   output logic [9:0]  lb_rdaddr,
   output logic        lb_ren,
   input  logic [63:0] lb_rddata,
   output logic [9:0]  lb_wraddr,
   output logic        lb_wen,
   output logic [63:0] lb_wrdata,
   output logic        pix_valid,
   output logic [14:0] pix_data,
   output logic        line_end,
   output logic        underrun
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   localparam logic [7:0] LAST_WORD = 8'(WORDS - 1);
   localparam logic [9:0] LAST_PIX  = 10'(4 * WORDS - 1);

   logic [1:0]  state;
   logic [1:0]  bank;
   logic [7:0]  rd_word;
   logic        rd_all;
   logic        inflight;
   logic [63:0] fifo_mem [2];
   logic        wr_ptr;
   logic        rd_ptr;
   logic [1:0]  occ;
   logic [1:0]  px_idx;
   logic [9:0]  pix_cnt;

   logic        issue;
   logic        avail;
   logic        pop_px;
   logic        pop_word;
   logic        push;
   logic [63:0] head_word;
   logic [15:0] head_px;

   // Read issue, pixel availability and head-pixel selection. Returning read data
   // counts as available in the cycle it appears so word 0 is usable at T+2.
   always_comb begin
      issue     = (state == RUN) && !line_start && !rd_all &&
                  ((occ + {1'b0, inflight}) < 2'd2);
      push      = inflight && !line_start;
      avail     = (occ != 2'd0) || inflight;
      pop_px    = (state == RUN) && !line_start && pix_en && avail;
      pop_word  = pop_px && (px_idx == 2'd3);
      head_word = (occ == 2'd0) ? lb_rddata : fifo_mem[rd_ptr];
      case (px_idx)
         2'd0:    head_px = head_word[15:0];
         2'd1:    head_px = head_word[31:16];
         2'd2:    head_px = head_word[47:32];
         default: head_px = head_word[63:48];
      endcase
   end

   assign lb_ren    = issue;
   assign lb_rdaddr = {bank, rd_word};

   // Word storage; contents need no reset because occupancy gates every use.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr] <= lb_rddata;
      end
   end

   // Scan FSM, read counter, FIFO bookkeeping and the registered pixel output.
   // line_start outranks everything so an abort flushes buffered and in-flight words.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         bank      <= 2'd0;
         rd_word   <= 8'd0;
         rd_all    <= 1'b0;
         inflight  <= 1'b0;
         wr_ptr    <= 1'b0;
         rd_ptr    <= 1'b0;
         occ       <= 2'd0;
         px_idx    <= 2'd0;
         pix_cnt   <= 10'd0;
         pix_valid <= 1'b0;
         pix_data  <= 15'd0;
         line_end  <= 1'b0;
         underrun  <= 1'b0;
      end else begin
         pix_valid <= 1'b0;
         line_end  <= 1'b0;
         if (line_start) begin
            state    <= RUN;
            bank     <= rd_bank;
            rd_word  <= 8'd0;
            rd_all   <= 1'b0;
            inflight <= 1'b0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            occ      <= 2'd0;
            px_idx   <= 2'd0;
            pix_cnt  <= 10'd0;
            underrun <= 1'b0;
         end else begin
            inflight <= issue;
            if (issue) begin
               if (rd_word == LAST_WORD) begin
                  rd_all <= 1'b1;
               end else begin
                  rd_word <= rd_word + 8'd1;
               end
            end
            if (push) begin
               wr_ptr <= ~wr_ptr;
            end
            if (pop_word) begin
               rd_ptr <= ~rd_ptr;
            end
            occ <= occ + {1'b0, push} - {1'b0, pop_word};
            if (pop_px) begin
               pix_valid <= 1'b1;
               pix_data  <= head_px[15] ? bg_color : head_px[14:0];
               px_idx    <= px_idx + 2'd1;
               pix_cnt   <= pix_cnt + 10'd1;
               if (pix_cnt == LAST_PIX) begin
                  line_end <= 1'b1;
                  state    <= DONE;
               end
            end
            if ((state == RUN) && pix_en && !avail) begin
               underrun <= 1'b1;
            end
            if (state == DONE) begin
               state <= IDLE;
            end
         end
      end
   end

`ifdef CV_LINESCAN_CLEAR_EN
   // Clear-after-read: rewrite each word one cycle after it was read so the bank is blank.
   always_ff @(posedge clk) begin
      if (reset) begin
         lb_wen    <= 1'b0;
         lb_wraddr <= 10'd0;
      end else begin
         lb_wen <= lb_ren;
         if (lb_ren) begin
            lb_wraddr <= lb_rdaddr;
         end
      end
   end
`else
   assign lb_wen    = 1'b0;
   assign lb_wraddr = 10'd0;
`endif

   assign lb_wrdata = lb_wen ? {4{CLR_PIX}} : 64'd0;

endmodule

// File: tb/tb_cv_linescan.sv
// tb_cv_linescan: randomized bench for cv_linescan with a queue-based pixel model,
// a behavioural line-buffer memory and literal checks for reset and the known first word.
module tb_cv_linescan;

   localparam int WORDS = 200;
   localparam int NPIX  = 4 * WORDS;

   logic        clk        = 1'b0;
   logic        reset      = 1'b1;
   logic        line_start = 1'b0;
   logic [1:0]  rd_bank    = 2'd0;
   logic        pix_en     = 1'b0;
   logic [14:0] bg_color   = 15'd0;
   logic [9:0]  lb_rdaddr;
   logic        lb_ren;
   logic [63:0] lb_rddata  = 64'd0;
   logic [9:0]  lb_wraddr;
   logic        lb_wen;
   logic [63:0] lb_wrdata;
   logic        pix_valid;
   logic [14:0] pix_data;
   logic        line_end;
   logic        underrun;

   int total = 0;
   int bad   = 0;

   // Line-buffer memory seen by the DUT, plus what the bench last wrote into it.
   logic [63:0] lbMem     [0:1023];
   logic [63:0] shadowMem [0:1023];
   logic        fillEn   = 1'b0;
   logic [9:0]  fillAddr = 10'd0;
   logic [63:0] fillData = 64'd0;

   // Model state for the current line.
   logic [15:0] rawQ [$];
   int          linePix   = 0;
   int          lineReads = 0;
   logic        active    = 1'b0;
   logic        lineDone  = 1'b0;
   logic [1:0]  curBank   = 2'd0;
   logic [14:0] firstPix [4];
   logic [9:0]  firstAddr = 10'd0;
   logic        sawWen    = 1'b0;
   int          penMode   = 0;

   always #5 clk = ~clk;

   cv_linescan #(.WORDS(WORDS), .CLR_PIX(16'h8000)) dut (
      .clk       (clk),
      .reset     (reset),
      .line_start(line_start),
      .rd_bank   (rd_bank),
      .pix_en    (pix_en),
      .bg_color  (bg_color),
      .lb_rdaddr (lb_rdaddr),
      .lb_ren    (lb_ren),
      .lb_rddata (lb_rddata),
      .lb_wraddr (lb_wraddr),
      .lb_wen    (lb_wen),
      .lb_wrdata (lb_wrdata),
      .pix_valid (pix_valid),
      .pix_data  (pix_data),
      .line_end  (line_end),
      .underrun  (underrun)
   );

   // Synchronous line-buffer RAM: read data one cycle after lb_ren, writes from DUT clears and bench fills.
   always @(posedge clk) begin
      if (lb_ren) lb_rddata <= lbMem[lb_rdaddr];
      if (lb_wen) lbMem[lb_wraddr] <= lb_wrdata;
      if (fillEn) lbMem[fillAddr] <= fillData;
   end

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Pixel-enable pattern generator: 0 off, 1 always, 2 every 4th cycle, 3 random.
   initial begin
      int cyc;
      cyc = 0;
      forever begin
         @(posedge clk);
         #2;
         cyc++;
         case (penMode)
            0:       pix_en = 1'b0;
            1:       pix_en = 1'b1;
            2:       pix_en = (cyc % 4 == 0);
            default: pix_en = ($urandom_range(0, 2) != 0);
         endcase
      end
   end

   // Reference model and compare: every word read is expanded into four expected pixels;
   // every pix_valid pops one and applies the transparency rule.
   always @(negedge clk) begin
      logic [15:0] raw;
      logic [14:0] expPix;
      if (reset) begin
         active = 1'b0;
         rawQ.delete();
      end else begin
         if (lb_wen) sawWen = 1'b1;
         if (pix_valid) begin
            if (!active || rawQ.size() == 0) begin
               total++;
               bad++;
               $display("[TB] FAIL pix_unexpected: got pix_valid=1 data=%0h required no pixel", pix_data);
            end else begin
               raw    = rawQ.pop_front();
               expPix = raw[15] ? bg_color : raw[14:0];
               linePix++;
               if (linePix <= 4) firstPix[linePix-1] = pix_data;
               checkOutput("pix_data", 64'(pix_data), 64'(expPix));
               checkOutput("line_end", 64'(line_end), 64'(linePix == NPIX));
               if (linePix == NPIX) begin
                  active   = 1'b0;
                  lineDone = 1'b1;
                  checkOutput("reads_per_line", 64'(lineReads), 64'(WORDS));
               end
            end
         end else if (line_end) begin
            total++;
            bad++;
            $display("[TB] FAIL line_end_alone: got line_end=1 required 0 without pix_valid");
         end
         if (lb_ren && !line_start) begin
            if (!active) begin
               total++;
               bad++;
               $display("[TB] FAIL ren_idle: got lb_ren=1 addr=%0h required no read", lb_rdaddr);
            end else begin
               checkOutput("rd_addr", 64'(lb_rdaddr), 64'({curBank, 8'(lineReads)}));
               if (lineReads == 0) firstAddr = lb_rdaddr;
               lineReads++;
               for (int k = 0; k < 4; k++) rawQ.push_back(lbMem[lb_rdaddr][16*k +: 16]);
               checkOutput("outstanding_le_2", 64'((lineReads - linePix / 4) <= 2), 64'd1);
            end
         end
         if (line_start) begin
            rawQ.delete();
            curBank   = rd_bank;
            linePix   = 0;
            lineReads = 0;
            active    = 1'b1;
            lineDone  = 1'b0;
         end
      end
   end

   task automatic fillBank(input logic [1:0] b, input bit literal0);
      for (int w = 0; w < WORDS; w++) begin
         logic [63:0] d;
         d = {$urandom, $urandom};
         if (literal0 && w == 0) d = 64'h8000_7FFF_0001_801F;
         tick();
         fillEn   = 1'b1;
         fillAddr = {b, 8'(w)};
         fillData = d;
         shadowMem[{b, 8'(w)}] = d;
      end
      tick();
      fillEn = 1'b0;
   endtask

   // One-cycle line_start; rd_bank is scrambled afterwards since it is only sampled on the pulse.
   task automatic applyStimulus(input logic [1:0] b);
      tick();
      line_start = 1'b1;
      rd_bank    = b;
      tick();
      line_start = 1'b0;
      rd_bank    = 2'($urandom_range(0, 3));
   endtask

   task automatic waitLine(input string name);
      int n;
      n = 0;
      while (!lineDone && n < 20000) begin
         @(negedge clk);
         n++;
      end
      if (!lineDone) begin
         total++;
         bad++;
         $display("[TB] FAIL %s: got %0d pixels required %0d within cycle budget", name, linePix, NPIX);
      end
      tick();
   endtask

   task automatic checkBank(input logic [1:0] b, input string name);
      int nbad;
      nbad = 0;
      repeat (3) tick();
      for (int w = 0; w < WORDS; w++) begin
`ifdef CV_LINESCAN_CLEAR_EN
         if (lbMem[{b, 8'(w)}] !== 64'h8000_8000_8000_8000) nbad++;
`else
         if (lbMem[{b, 8'(w)}] !== shadowMem[{b, 8'(w)}]) nbad++;
`endif
      end
      checkOutput(name, 64'(nbad), 64'd0);
`ifndef CV_LINESCAN_CLEAR_EN
      checkOutput("lb_wen_never", 64'(sawWen), 64'd0);
`endif
   endtask

   task automatic checkZeroOutputs(input string name);
      checkOutput(name, {24'd0, lb_ren, lb_rdaddr, lb_wen, lb_wraddr, pix_valid, pix_data, line_end, underrun}, 64'd0);
      checkOutput({name, "_wrdata"}, lb_wrdata, 64'd0);
   endtask

   initial begin
      int n;
      logic [1:0] b;
      $display("[TB] cv_linescan bench start");
      reset = 1'b1;
      for (int i = 0; i < 4; i++) fillBank(2'(i), (i == 2));
      @(negedge clk);
      checkZeroOutputs("reset_state");
      tick();
      reset = 1'b0;

      // Reset asserted mid-line: outputs return to zero and nothing moves until line_start.
      penMode = 1;
      applyStimulus(2'd0);
      repeat (50) tick();
      reset = 1'b1;
      tick();
      @(negedge clk);
      checkZeroOutputs("midrun_reset");
      tick();
      tick();
      reset   = 1'b0;
      penMode = 3;
      @(negedge clk);
      checkZeroOutputs("after_reset");
      repeat (20) tick();
      checkOutput("no_underrun_idle", 64'(underrun), 64'd0);
      penMode = 0;
      if (shadowMem[10'h200] !== 64'h8000_7FFF_0001_801F || lbMem[10'h200] !== shadowMem[10'h200]) fillBank(2'd2, 1'b1);

      // Known first word, continuous pixel enable from the first data cycle.
      bg_color = 15'h1234;
      applyStimulus(2'd2);
      tick();
      penMode = 1;
      waitLine("line_bank2");
      checkOutput("first_rdaddr", 64'(firstAddr), 64'h200);
      checkOutput("first_px0", 64'(firstPix[0]), 64'h1234);
      checkOutput("first_px1", 64'(firstPix[1]), 64'h0001);
      checkOutput("first_px2", 64'(firstPix[2]), 64'h7FFF);
      checkOutput("first_px3", 64'(firstPix[3]), 64'h1234);
      checkOutput("pixels_bank2", 64'(linePix), 64'(NPIX));
      checkOutput("underrun_bank2", 64'(underrun), 64'd0);
      penMode = 3;
      repeat (10) tick();
      penMode = 0;
      checkBank(2'd2, "bank2_contents");

      // Slow pixel rate: every fourth cycle.
      fillBank(2'd1, 1'b0);
      bg_color = 15'($urandom);
      applyStimulus(2'd1);
      tick();
      penMode = 2;
      waitLine("line_slow");
      checkOutput("pixels_slow", 64'(linePix), 64'(NPIX));
      checkOutput("underrun_slow", 64'(underrun), 64'd0);
      penMode = 0;

      // Pixels demanded before any data has returned: stalls, flags underrun, loses nothing.
      fillBank(2'd3, 1'b0);
      bg_color = 15'($urandom);
      penMode  = 1;
      applyStimulus(2'd3);
      waitLine("line_underrun");
      checkOutput("pixels_underrun", 64'(linePix), 64'(NPIX));
      checkOutput("underrun_set", 64'(underrun), 64'd1);
      penMode = 0;

      // Abort after 300 pixels, right after a read so its returning data must be dropped.
      fillBank(2'd0, 1'b0);
      fillBank(2'd1, 1'b0);
      bg_color = 15'($urandom);
      penMode  = 1;
      applyStimulus(2'd0);
      n = 0;
      while (linePix < 300 && n < 5000) begin
         @(negedge clk);
         n++;
      end
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!lb_ren && n < 20);
      checkOutput("abort_read_seen", 64'(lb_ren), 64'd1);
      checkOutput("underrun_before_abort", 64'(underrun), 64'd1);
      penMode = 0;
      applyStimulus(2'd1);
      @(negedge clk);
      checkOutput("underrun_cleared", 64'(underrun), 64'd0);
      tick();
      penMode = 1;
      waitLine("line_restart");
      checkOutput("restart_first_addr", 64'(firstAddr), 64'h100);
      checkOutput("pixels_restart", 64'(linePix), 64'(NPIX));
      checkOutput("underrun_restart", 64'(underrun), 64'd0);
      penMode = 0;
      checkBank(2'd1, "bank1_contents");

      // Random banks, colours and pixel-enable patterns.
      for (int i = 0; i < 2; i++) begin
         b = 2'($urandom_range(0, 3));
         fillBank(b, 1'b0);
         bg_color = 15'($urandom);
         applyStimulus(b);
         tick();
         penMode = 3;
         waitLine("line_random");
         checkOutput("pixels_random", 64'(linePix), 64'(NPIX));
         penMode = 0;
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
